// File: rtl/sift_pkg.sv
// Shared types and constants for the SIFT front-end pixel pipeline.
package sift_pkg;

  localparam int PIX_W      = 8;
  localparam int IMG_W_DEF  = 640;
  localparam int IMG_H_DEF  = 480;
  localparam int WIN_CENTRE = 4;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } win_state_e;

  // Flat tap index of window element (row i, col j), both counted from the oldest.
  function automatic int win_idx(input int i, input int j);
    return 3 * i + j;
  endfunction

endpackage

// File: rtl/line_delay.sv
// One-row pixel delay: dout is the sample written exactly IMG_W enables ago,
// read from the slot about to be overwritten (read-before-write).
module line_delay
  import sift_pkg::*;
#(
  parameter int DATA_W = PIX_W,
  parameter int IMG_W  = IMG_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  localparam int PTR_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(IMG_W - 1);

  logic [DATA_W-1:0] mem_r [IMG_W];
  logic [PTR_W-1:0]  ptr_r;

  // Circular write pointer, advances once per enabled sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= '0;
    end else if (ce) begin
      if (ptr_r == PTR_LAST) begin
        ptr_r <= '0;
      end else begin
        ptr_r <= ptr_r + PTR_W'(1);
      end
    end
  end

  // Storage is deliberately not cleared; downstream gating hides stale contents.
  always_ff @(posedge clk) begin
    if (ce) begin
      mem_r[ptr_r] <= din;
    end
  end

  assign dout = mem_r[ptr_r];

endmodule

// File: rtl/window_3x3_gen.sv
// 3x3 neighbourhood generator over a raster pixel stream; emits interior windows only.
// Optional WIN_COORD_EN adds registered centre coordinates win_row/win_col.
module window_3x3_gen
  import sift_pkg::*;
#(
  parameter int DATA_W = PIX_W,
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sclr,
  input  logic [DATA_W-1:0]     pix_in,
  input  logic                  pix_valid,
  input  logic                  sof,
  output logic [9*DATA_W-1:0]   win,
  output logic                  win_valid,
  output logic                  frame_done,
`ifdef WIN_COORD_EN
  output logic [$clog2(IMG_H)-1:0] win_row,
  output logic [$clog2(IMG_W)-1:0] win_col,
`endif
  output logic                  drop
);

  localparam int ROW_W = $clog2(IMG_H);
  localparam int COL_W = $clog2(IMG_W);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);

  win_state_e         state_r;
  logic [ROW_W-1:0]   row_r;
  logic [COL_W-1:0]   col_r;
  logic [ROW_W-1:0]   cur_row_s;
  logic [COL_W-1:0]   cur_col_s;
  logic               accept_s;
  logic               is_last_s;
  logic               win_hit_s;
  logic [DATA_W-1:0]  ld0_out_s;
  logic [DATA_W-1:0]  ld1_out_s;
  logic [DATA_W-1:0]  arr_r   [3][3];
  logic [DATA_W-1:0]  arr_nxt_s [3][3];
  logic [9*DATA_W-1:0] win_nxt_s;
  logic [9*DATA_W-1:0] win_r;
  logic               win_valid_r;
  logic               frame_done_r;
  logic               drop_r;
`ifdef WIN_COORD_EN
  logic [ROW_W-1:0]   win_row_r;
  logic [COL_W-1:0]   win_col_r;
`endif

  assign accept_s  = pix_valid && ((state_r == ST_ACTIVE) || sof);
  assign is_last_s = !sof && (cur_row_s == ROW_LAST) && (cur_col_s == COL_LAST);
  assign win_hit_s = (cur_row_s >= ROW_W'(2)) && (cur_col_s >= COL_W'(2));

  // Coordinates of the pixel on the input; sof forces a restart at (0,0).
  always_comb begin
    if (sof) begin
      cur_row_s = '0;
      cur_col_s = '0;
    end else begin
      cur_row_s = row_r;
      cur_col_s = col_r;
    end
  end

  line_delay #(.DATA_W(DATA_W), .IMG_W(IMG_W)) u_ld0 (
    .clk(clk), .rst_n(rst_n), .ce(accept_s), .din(pix_in), .dout(ld0_out_s)
  );

  line_delay #(.DATA_W(DATA_W), .IMG_W(IMG_W)) u_ld1 (
    .clk(clk), .rst_n(rst_n), .ce(accept_s), .din(ld0_out_s), .dout(ld1_out_s)
  );

  // Next array: shift columns left, newest column from the line delays and input.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 2; j++) begin
        arr_nxt_s[i][j] = arr_r[i][j+1];
      end
    end
    arr_nxt_s[0][2] = ld1_out_s;
    arr_nxt_s[1][2] = ld0_out_s;
    arr_nxt_s[2][2] = pix_in;
    win_nxt_s = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        win_nxt_s[DATA_W*win_idx(i, j) +: DATA_W] = arr_nxt_s[i][j];
      end
    end
  end

  // 3x3 register array, advanced on every accepted pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arr_r <= '{default: '0};
    end else if (sclr) begin
      arr_r <= '{default: '0};
    end else if (accept_s) begin
      arr_r <= arr_nxt_s;
    end
  end

  // Frame FSM, raster counters and registered window outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      row_r        <= '0;
      col_r        <= '0;
      win_r        <= '0;
      win_valid_r  <= 1'b0;
      frame_done_r <= 1'b0;
      drop_r       <= 1'b0;
`ifdef WIN_COORD_EN
      win_row_r    <= '0;
      win_col_r    <= '0;
`endif
    end else if (sclr) begin
      state_r      <= ST_IDLE;
      row_r        <= '0;
      col_r        <= '0;
      win_r        <= '0;
      win_valid_r  <= 1'b0;
      frame_done_r <= 1'b0;
      drop_r       <= 1'b0;
`ifdef WIN_COORD_EN
      win_row_r    <= '0;
      win_col_r    <= '0;
`endif
    end else begin
      win_valid_r  <= 1'b0;
      frame_done_r <= 1'b0;
      drop_r       <= 1'b0;
      if (accept_s) begin
        if (is_last_s) begin
          state_r      <= ST_IDLE;
          row_r        <= '0;
          col_r        <= '0;
          frame_done_r <= 1'b1;
        end else begin
          state_r <= ST_ACTIVE;
          if (cur_col_s == COL_LAST) begin
            row_r <= cur_row_s + ROW_W'(1);
            col_r <= '0;
          end else begin
            row_r <= cur_row_s;
            col_r <= cur_col_s + COL_W'(1);
          end
        end
        if (win_hit_s) begin
          win_valid_r <= 1'b1;
          win_r       <= win_nxt_s;
`ifdef WIN_COORD_EN
          win_row_r   <= cur_row_s - ROW_W'(1);
          win_col_r   <= cur_col_s - COL_W'(1);
`endif
        end
      end else if (pix_valid) begin
        drop_r <= 1'b1;
      end
    end
  end

  assign win        = win_r;
  assign win_valid  = win_valid_r;
  assign frame_done = frame_done_r;
  assign drop       = drop_r;
`ifdef WIN_COORD_EN
  assign win_row    = win_row_r;
  assign win_col    = win_col_r;
`endif

endmodule

// File: tb/tb_window_3x3_gen.sv
// Self-checking bench for window_3x3_gen at IMG_W=5, IMG_H=4 using a frame-buffer scoreboard.
module tb_window_3x3_gen;
  import sift_pkg::*;

  localparam int DW = 8;
  localparam int W  = 5;
  localparam int H  = 4;
  localparam int RW = $clog2(H);
  localparam int CW = $clog2(W);

  logic clk = 1'b0;
  logic rst_n, sclr, pix_valid, sof;
  logic [DW-1:0]   pix_in;
  logic [9*DW-1:0] win;
  logic win_valid, frame_done, drop;
`ifdef WIN_COORD_EN
  logic [RW-1:0] win_row;
  logic [CW-1:0] win_col;
`endif

  always #5 clk = ~clk;

  window_3x3_gen #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst_n(rst_n), .sclr(sclr), .pix_in(pix_in), .pix_valid(pix_valid),
    .sof(sof), .win(win), .win_valid(win_valid), .frame_done(frame_done),
`ifdef WIN_COORD_EN
    .win_row(win_row), .win_col(win_col),
`endif
    .drop(drop)
  );

  typedef struct {
    logic [9*DW-1:0] w;
    int r;
    int c;
  } exp_t;

  typedef struct {
    logic          v;
    logic          s;
    logic [DW-1:0] p;
    logic          exp_wv;
    logic          exp_drop;
    logic          exp_fd;
    logic [DW-1:0] exp_w0;
    logic [DW-1:0] exp_centre;
    logic [DW-1:0] exp_w8;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl[W*H+1];
  int checks = 0;
  int errors = 0;
  int win_seen = 0;

  bit      m_active;
  int      m_row, m_col;
  logic [DW-1:0] fm[H][W];

  task automatic chk(input string name, input logic [9*DW-1:0] act, input logic [9*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_row = 0;
    m_col = 0;
    sb_q.delete();
  endtask

  // Drive one cycle, update the reference model, then check the registered outputs.
  task automatic step(input logic v, input logic s, input logic [DW-1:0] p);
    bit acc, exp_fd, exp_drop;
    int r, c;
    exp_t e;
    acc = v && (m_active || s);
    exp_fd = 1'b0;
    exp_drop = v && !acc;
    if (acc) begin
      r = s ? 0 : m_row;
      c = s ? 0 : m_col;
      fm[r][c] = p;
      if (r >= 2 && c >= 2) begin
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            e.w[DW*(3*i+j) +: DW] = fm[r-2+i][c-2+j];
        e.r = r - 1;
        e.c = c - 1;
        sb_q.push_back(e);
      end
      if (r == H-1 && c == W-1) begin
        exp_fd = 1'b1;
        m_active = 1'b0;
        m_row = 0;
        m_col = 0;
      end else begin
        m_active = 1'b1;
        m_row = (c == W-1) ? r + 1 : r;
        m_col = (c == W-1) ? 0 : c + 1;
      end
    end
    pix_valid = v;
    sof = s;
    pix_in = p;
    @(posedge clk);
    #1;
    chk("frame_done", frame_done, exp_fd);
    chk("drop", drop, exp_drop);
    chk("win_valid", win_valid, sb_q.size() != 0);
    if (win_valid && sb_q.size() != 0) begin
      e = sb_q.pop_front();
      win_seen++;
      chk("win", win, e.w);
`ifdef WIN_COORD_EN
      chk("win_row", win_row, e.r);
      chk("win_col", win_col, e.c);
`endif
    end
    sb_q.delete();
    pix_valid = 1'b0;
    sof = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_win"}, win, '0);
    chk({tag, "_win_valid"}, win_valid, 1'b0);
    chk({tag, "_frame_done"}, frame_done, 1'b0);
    chk({tag, "_drop"}, drop, 1'b0);
`ifdef WIN_COORD_EN
    chk({tag, "_win_row"}, win_row, '0);
    chk({tag, "_win_col"}, win_col, '0);
`endif
  endtask

  task automatic run_frame(input int base, input bit gaps);
    for (int k = 0; k < W*H; k++) begin
      if (gaps) begin
        while ($urandom_range(0, 99) < 30) step(1'b0, 1'b0, 8'd0);
      end
      step(1'b1, k == 0, DW'(base + 10*(k / W) + (k % W)));
    end
  endtask

  initial begin
    rst_n = 1'b0; sclr = 1'b0; pix_valid = 1'b0; sof = 1'b0; pix_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;

    // Table: one discarded pixel in IDLE, then the 5x4 ramp frame.
    tbl[0] = '{1'b1, 1'b0, 8'd99, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0};
    for (int k = 1; k <= W*H; k++) begin
      int r, c;
      r = (k - 1) / W;
      c = (k - 1) % W;
      tbl[k].v = 1'b1;
      tbl[k].s = (k == 1);
      tbl[k].p = DW'(10*r + c);
      tbl[k].exp_wv = (r >= 2 && c >= 2);
      tbl[k].exp_drop = 1'b0;
      tbl[k].exp_fd = (r == H-1 && c == W-1);
      tbl[k].exp_w0 = DW'(10*(r-2) + (c-2));
      tbl[k].exp_centre = DW'(10*(r-1) + (c-1));
      tbl[k].exp_w8 = DW'(10*r + c);
    end
    win_seen = 0;
    for (int k = 0; k <= W*H; k++) begin
      step(tbl[k].v, tbl[k].s, tbl[k].p);
      chk("tbl_win_valid", win_valid, tbl[k].exp_wv);
      chk("tbl_drop", drop, tbl[k].exp_drop);
      chk("tbl_frame_done", frame_done, tbl[k].exp_fd);
      if (tbl[k].exp_wv) begin
        chk("tbl_w0", win[0 +: DW], tbl[k].exp_w0);
        chk("tbl_centre", win[DW*WIN_CENTRE +: DW], tbl[k].exp_centre);
        chk("tbl_w8", win[DW*8 +: DW], tbl[k].exp_w8);
      end
    end
    chk("ramp_window_count", win_seen, (H-2)*(W-2));

    // Random idle gaps must not change the window sequence.
    win_seen = 0;
    run_frame(0, 1'b1);
    chk("gap_window_count", win_seen, (H-2)*(W-2));

    // Repeated non-sof pixels in IDLE stay dropped; then a clean frame.
    step(1'b1, 1'b0, 8'd7);
    step(1'b1, 1'b0, 8'd8);
    win_seen = 0;
    run_frame(30, 1'b0);
    chk("after_drop_window_count", win_seen, (H-2)*(W-2));

    // sof at (2,3) aborts the frame and restarts counting.
    for (int k = 0; k <= 2*W + 2; k++) step(1'b1, k == 0, DW'(60 + k));
    win_seen = 0;
    step(1'b1, 1'b1, 8'd200);
    for (int k = 1; k < W*H; k++) step(1'b1, 1'b0, DW'(120 + 10*(k / W) + (k % W)));
    chk("restart_window_count", win_seen, (H-2)*(W-2));

    // Asynchronous reset between edges, right after a window was emitted.
    for (int k = 0; k <= 2*W + 2; k++) step(1'b1, k == 0, DW'(70 + 3*k));
    chk("pre_reset_win_valid", win_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    step(1'b1, 1'b0, 8'd5);
    win_seen = 0;
    run_frame(150, 1'b0);
    chk("post_reset_window_count", win_seen, (H-2)*(W-2));

    // Synchronous clear mid-frame returns to IDLE.
    for (int k = 0; k <= 2*W + 2; k++) step(1'b1, k == 0, DW'(90 + k));
    sclr = 1'b1;
    @(posedge clk);
    #1;
    sclr = 1'b0;
    model_reset();
    check_outputs_zero("sclr");
    step(1'b1, 1'b0, 8'd3);
    win_seen = 0;
    run_frame(40, 1'b1);
    chk("post_sclr_window_count", win_seen, (H-2)*(W-2));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
